// File: rtl/mem_write_checker.sv
// Store-port checker: matches core writes against a programmable table of expected
// stores and ignored addresses, and reports pass or fail with the failing write captured.
module mem_write_checker #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_EXP = 4,
    parameter int unsigned NUM_IGN = 2,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned IDX_W   = ($clog2(NUM_EXP) > $clog2(NUM_IGN))
                                     ? (($clog2(NUM_EXP) > 1) ? $clog2(NUM_EXP) : 1)
                                     : (($clog2(NUM_IGN) > 1) ? $clog2(NUM_IGN) : 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              ordered,
    input  logic [IDX_W:0]    exp_count,
    input  logic              start,
    input  logic              cfg_we,
    input  logic              cfg_ign,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [IDX_W:0]    match_count
);

    localparam int unsigned CW   = IDX_W + 1;
    localparam int unsigned TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned TLIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_exp_addr [NUM_EXP];
    logic [DATA_W-1:0]   r_exp_data [NUM_EXP];
    logic [ADDR_W-1:0]   r_ign_addr [NUM_IGN];
    logic [NUM_IGN-1:0]  r_ign_vld;
    logic [NUM_EXP-1:0]  r_seen;
    logic                r_ordered;
    logic [CW-1:0]       r_exp_cnt;
    logic [CW-1:0]       r_match_cnt;
    logic [TW-1:0]       r_cyc;
    logic [1:0]          r_fail_code;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [DATA_W-1:0]   r_fail_data;

    logic                w_run;
    logic                w_ord_hit, w_ord_later, w_un_hit, w_ign_hit;
    logic [NUM_EXP-1:0]  w_un_oh;
    logic                w_match, w_complete, w_wfail, w_timeout;
    logic [1:0]          w_wcode;
    logic [CW-1:0]       w_new_cnt;

    assign w_run = (r_state == S_RUN);

    // Table lookup: ordered slot hit, later-slot hit, lowest unseen hit, ignore hit
    always_comb begin
        w_ord_hit   = 1'b0;
        w_ord_later = 1'b0;
        w_un_hit    = 1'b0;
        w_un_oh     = '0;
        w_ign_hit   = 1'b0;
        for (int i = 0; i < int'(NUM_EXP); i++) begin
            if ((CW'(i) < r_exp_cnt) && (r_exp_addr[i] == DataAdr) && (r_exp_data[i] == WriteData)) begin
                if (CW'(i) == r_match_cnt) w_ord_hit = 1'b1;
                if (CW'(i) > r_match_cnt)  w_ord_later = 1'b1;
                if (!r_seen[i] && !w_un_hit) begin
                    w_un_hit   = 1'b1;
                    w_un_oh[i] = 1'b1;
                end
            end
        end
        for (int j = 0; j < int'(NUM_IGN); j++) begin
            if (r_ign_vld[j] && (r_ign_addr[j] == DataAdr)) w_ign_hit = 1'b1;
        end
    end

    assign w_match    = w_run && MemWrite && (r_ordered ? w_ord_hit : w_un_hit);
    assign w_new_cnt  = r_match_cnt + CW'(1);
    assign w_complete = w_match && (w_new_cnt == r_exp_cnt);
    assign w_wfail    = w_run && MemWrite && !w_match && ((r_ordered && w_ord_later) || !w_ign_hit);
    assign w_wcode    = (r_ordered && w_ord_later) ? 2'd3 : 2'd1;
    assign w_timeout  = (TIMEOUT != 0) && w_run && (r_cyc == TW'(TLIM));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; a completing match outranks both write failure and timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_complete)     w_state_nxt = S_PASS;
                else if (w_wfail)   w_state_nxt = S_FAIL;
                else if (w_timeout) w_state_nxt = S_FAIL;
            end
            default: begin
                if (start) w_state_nxt = S_RUN;
            end
        endcase
    end

    // Tables, run bookkeeping and failure capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_EXP); i++) begin
                r_exp_addr[i] <= '0;
                r_exp_data[i] <= '0;
            end
            for (int j = 0; j < int'(NUM_IGN); j++) r_ign_addr[j] <= '0;
            r_ign_vld   <= '0;
            r_seen      <= '0;
            r_ordered   <= 1'b0;
            r_exp_cnt   <= '0;
            r_match_cnt <= '0;
            r_cyc       <= '0;
            r_fail_code <= 2'd0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            if (!w_run && cfg_we) begin
                if (cfg_ign) begin
                    for (int j = 0; j < int'(NUM_IGN); j++) begin
                        if (cfg_idx == IDX_W'(j)) begin
                            r_ign_addr[j] <= cfg_addr;
                            r_ign_vld[j]  <= 1'b1;
                        end
                    end
                end else begin
                    for (int i = 0; i < int'(NUM_EXP); i++) begin
                        if (cfg_idx == IDX_W'(i)) begin
                            r_exp_addr[i] <= cfg_addr;
                            r_exp_data[i] <= cfg_data;
                        end
                    end
                end
            end
            if (!w_run && start) begin
                r_seen      <= '0;
                r_match_cnt <= '0;
                r_cyc       <= '0;
                r_fail_code <= 2'd0;
                r_fail_addr <= '0;
                r_fail_data <= '0;
                r_ordered   <= ordered;
                if (exp_count == '0)                r_exp_cnt <= CW'(1);
                else if (exp_count > CW'(NUM_EXP)) r_exp_cnt <= CW'(NUM_EXP);
                else                                r_exp_cnt <= exp_count;
            end else if (w_run) begin
                if (r_cyc != {TW{1'b1}}) r_cyc <= r_cyc + TW'(1);
                if (w_match) begin
                    r_match_cnt <= w_new_cnt;
                    if (!r_ordered) r_seen <= r_seen | w_un_oh;
                end
                if (!w_complete) begin
                    if (w_wfail) begin
                        r_fail_code <= w_wcode;
                        r_fail_addr <= DataAdr;
                        r_fail_data <= WriteData;
                    end else if (w_timeout) begin
                        r_fail_code <= 2'd2;
                    end
                end
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy        = (r_state == S_RUN);
        pass        = (r_state == S_PASS);
        fail        = (r_state == S_FAIL);
        fail_code   = r_fail_code;
        fail_addr   = r_fail_addr;
        fail_data   = r_fail_data;
        match_count = r_match_cnt;
    end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable bus-write checker that watches the core's data-memory write port (MemWrite, DataAdr, WriteData) and decides pass/fail against a programmable table of expected stores and ignored addresses. It generalises the single fixed pass/fail check to N expected writes, M ignore addresses, ordered/unordered matching, a timeout, and failure capture. It sits beside `top` in simulation and FPGA self-test builds and drives status LEDs/registers.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_EXP, 4, expected-write table depth (>=1)
- NUM_IGN, 2, ignore-address table depth (>=1)
- TIMEOUT, 1024, max RUN cycles before failure; 0 disables timeout
- IDX_W, max($clog2(NUM_EXP),$clog2(NUM_IGN),1), config index width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- MemWrite  in  1  store strobe from core
- DataAdr  in  ADDR_W  store address
- WriteData  in  DATA_W  store data
- ordered  in  1  1 = expected entries must match in index order; sampled on start
- exp_count  in  IDX_W+1  active expected entries (1..NUM_EXP); sampled on start
- start  in  1  arm/re-arm; one-cycle pulse
- cfg_we  in  1  table write strobe
- cfg_ign  in  1  0 = expected table, 1 = ignore table
- cfg_idx  in  IDX_W  table entry
- cfg_addr  in  ADDR_W  entry address
- cfg_data  in  DATA_W  entry data (unused for ignore table)
- busy  out  1  state is RUN
- pass  out  1  state is PASS
- fail  out  1  state is FAIL
- fail_code  out  2  0 none, 1 unexpected write, 2 timeout, 3 out-of-order
- fail_addr  out  ADDR_W  DataAdr of failing write (0 on timeout)
- fail_data  out  DATA_W  WriteData of failing write (0 on timeout)
- match_count  out  IDX_W+1  expected entries matched this run

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset -> IDLE; all outputs 0, both tables cleared, all ignore-valid bits 0.
- cfg_we writes entry cfg_idx of selected table (ignore write also sets its valid bit) in IDLE/PASS/FAIL; ignored in RUN. cfg_idx beyond table depth ignored. Tables persist across runs.
- start in IDLE/PASS/FAIL -> RUN: clears match_count, seen bits, cycle counter, fail_code/addr/data; latches ordered, exp_count (0 treated as 1, >NUM_EXP clamped). start in RUN ignored.
- In RUN, each rising edge with MemWrite=1, priority order:
  1. Ordered: (DataAdr,WriteData) equals entry match_count -> match_count+1. Unordered: equals any active, unseen entry -> set lowest such seen bit, match_count+1.
  2. Ordered only: equals a later active entry -> FAIL, code 3.
  3. DataAdr equals any valid ignore entry (data don't-care) -> no effect. Repeat of already-seen/matched entry falls to this rule.
  4. Otherwise -> FAIL, code 1, capture DataAdr/WriteData.
- match_count reaching exp_count -> PASS.
- PASS/FAIL hold until start or reset; MemWrite ignored there.
- Timeout: counter counts RUN cycles from 0; at count TIMEOUT-1 with no completing match that edge -> FAIL, code 2. Counter saturates; it does not wrap.

## Timing
- Single-cycle decisions; busy/pass/fail/fail_*/match_count registered, visible the cycle after the deciding edge.
- busy rises the cycle after start; a MemWrite on the start edge is not checked.
- Completing match and timeout on the same edge -> PASS.
- reset mid-run: immediate IDLE, outputs 0, tables cleared.
- Comparisons full width, exact equality; no byte masks.

## Test plan
- Program exp0=(100,25), ign0=96, exp_count=1, start; writes (96,7) then (100,25) -> pass=1, match_count=1, fail=0.
- Same setup; write (104,3) -> fail=1, fail_code=1, fail_addr=104, fail_data=3 one cycle later.
- ordered=1, exp0=(16,1), exp1=(20,2), exp_count=2; write (20,2) -> fail_code=3. Re-start, write (16,1),(20,2) -> pass.
- ordered=0, same table; writes (20,2),(16,1) -> pass; repeat (20,2) before completion with no ignore -> fail_code=1.
- TIMEOUT=8, no writes -> fail_code=2 exactly 8 cycles after busy rises; completing match on timeout edge -> pass instead.
- Assert reset low in RUN after one match -> all outputs 0 immediately; cfg_we during RUN leaves table unchanged (verify by next run).
